stack_op_sequencer: RTL and testbench
=====================================

STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 Parameter INT_VECTOR, default 32'h0000_0000: PC loaded after interrupt save completes.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 int_req / rti_req / call_req / ret_req  in  1 each  level requests, held by requester until ack.
REQ-005 pc  in  32  PC to save (interrupt: PC of interrupted instruction; call: return address).
REQ-006 target  in  32  call/jump destination, sampled with call_req.
REQ-007 flags  in  3  execute-unit flags to save on interrupt.
REQ-008 pop_data  in  16  data-memory stack read, valid exactly 1 cycle after pop_signal.
REQ-009 push_signal / pop_signal  out  1 each  stack command to data memory, one word per cycle.
REQ-010 push_data  out  16  word written at push.
REQ-011 ack  out  1  one-cycle pulse in the cycle a request is accepted.
REQ-012 stall  out  1  freezes fetch/decode while busy.
REQ-013 pc_load  out  1  one-cycle pulse; pc_out valid.
REQ-014 pc_out  out  32  next PC.
REQ-015 flags_load  out  1  one-cycle pulse; flags_out valid.
REQ-016 flags_out  out  3  restored flags.

Function
REQ-017 States SHALL be: IDLE, PUSH_HI, PUSH_LO, PUSH_FL, POP_FL, POP_LO, POP_HI, CAPTURE, LOAD.
REQ-018 Requests SHALL be sampled only in IDLE; priority int > rti > ret > call; losers get no ack.
REQ-019 On acceptance: ack=1, stall=1, pc/target/flags latched internally, op recorded.
REQ-020 INT: PUSH_HI (pc[31:16]) -> PUSH_LO (pc[15:0]) -> PUSH_FL ({13'b0,flags}) -> LOAD (pc_out=INT_VECTOR) -> IDLE.
REQ-021 CALL: PUSH_HI -> PUSH_LO -> LOAD (pc_out=latched target) -> IDLE.
REQ-022 RTI: POP_FL -> POP_LO -> POP_HI -> CAPTURE -> LOAD -> IDLE; each pop state asserts pop_signal.
REQ-023 pop_data SHALL be captured one cycle after its pop: flags at POP_LO (bits 2:0), pc lo at POP_HI, pc hi at CAPTURE.
REQ-024 RET: POP_LO -> POP_HI -> CAPTURE -> LOAD -> IDLE; flags_load stays 0.
REQ-025 In LOAD: pc_load=1; flags_load=1 only for RTI; stall=1.
REQ-026 stall SHALL be 1 from ack cycle through LOAD inclusive, 0 in IDLE otherwise.
REQ-027 push_signal and pop_signal SHALL never be 1 together; at most one stack word per cycle.
REQ-028 Latency: INT 5 cycles, CALL 4, RTI 6, RET 5 from ack to return to IDLE.
REQ-029 pc_out/flags_out SHALL hold their last value outside LOAD.
REQ-030 New requests in the LOAD cycle SHALL be ignored; earliest next ack is the cycle after LOAD.

Reset
REQ-031 rst SHALL force IDLE and zero every output and latch, including mid-sequence.
REQ-032 A sequence aborted by rst SHALL NOT produce pc_load, flags_load or further pushes/pops.

Structure
REQ-033 State encoding, op codes (OP_INT, OP_RTI, OP_CALL, OP_RET) and stack word order SHALL live in a shared package.
REQ-034 One sub-module, stack_word_assembler, SHALL capture pop_data into pc/flags registers.
REQ-035 No stack pointer inside this block; data memory owns SP.

Verification
REQ-036 INT, pc=0x0001_2345, flags=3'b101 -> pushes 0x0001,0x2345,0x0005 on 3 consecutive cycles, then pc_load with pc_out=INT_VECTOR.
REQ-037 RTI, pop_data returns 0x0005,0x2345,0x0001 -> pc_out=0x0001_2345, flags_out=3'b101, pc_load and flags_load pulse together.
REQ-038 int_req and call_req together in IDLE -> INT acked; call_req held -> acked cycle after INT LOAD.
REQ-039 CALL target=0x0000_0040, pc=0x0000_0011, then RET -> pushes 0x0000,0x0011; RET yields pc_out=0x0000_0011.
REQ-040 rst during PUSH_LO -> next cycle all outputs 0, state IDLE, no pc_load.
REQ-041 Assert every cycle: not (push_signal and pop_signal); stall=0 whenever IDLE and no ack.

Source files
------------

// File: rtl/stack_op_sequencer_pkg.sv
// Shared types for the stack operation sequencer: FSM states, request ops
// and the order in which the saved context is laid out on the stack.
package stack_op_sequencer_pkg;

    localparam int FLAGS_W = 3;

    typedef enum logic [3:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        PUSH_FL,
        POP_FL,
        POP_LO,
        POP_HI,
        CAPTURE,
        LOAD
    } state_e;

    typedef enum logic [1:0] {
        OP_INT,
        OP_RTI,
        OP_CALL,
        OP_RET
    } op_e;

    // Push order is PC high, PC low, flags; pops walk the same list backwards.
    typedef enum logic [1:0] {
        WORD_PC_HI,
        WORD_PC_LO,
        WORD_FLAGS
    } word_e;

    function automatic logic [15:0] stack_word(input word_e w,
                                               input logic [31:0] pc,
                                               input logic [FLAGS_W-1:0] flags);
        case (w)
            WORD_PC_HI: return pc[31:16];
            WORD_PC_LO: return pc[15:0];
            default:    return {{(16-FLAGS_W){1'b0}}, flags};
        endcase
    endfunction

endpackage

// File: rtl/stack_op_sequencer_assembler.sv
// Collects the words popped off the data-memory stack into a PC and flags
// value; pop_data arrives one cycle after its pop, so each enable is late by one.
module stack_word_assembler
    import stack_op_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        pop_data,
    input  logic               cap_flags,
    input  logic               cap_lo,
    input  logic               cap_hi,
    output logic [31:0]        pc_word,
    output logic [FLAGS_W-1:0] flags_word
);
    logic [31:0]        pc_q;
    logic [FLAGS_W-1:0] flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            flags_q <= '0;
        end else begin
            if (cap_flags) flags_q       <= pop_data[FLAGS_W-1:0];
            if (cap_lo)    pc_q[15:0]    <= pop_data;
            if (cap_hi)    pc_q[31:16]   <= pop_data;
        end
    end

    // The high half is forwarded straight through so the PC is usable on the capture edge.
    assign pc_word    = cap_hi ? {pop_data, pc_q[15:0]} : pc_q;
    assign flags_word = flags_q;

endmodule

// File: rtl/stack_op_sequencer.sv
// Sequences interrupt entry, call, RTI and RET through the data-memory stack,
// one word per cycle, then loads the new PC (and flags on RTI).
module stack_op_sequencer
    import stack_op_sequencer_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               int_req,
    input  logic               rti_req,
    input  logic               call_req,
    input  logic               ret_req,
    input  logic [31:0]        pc,
    input  logic [31:0]        target,
    input  logic [FLAGS_W-1:0] flags,
    input  logic [15:0]        pop_data,
    output logic               push_signal,
    output logic               pop_signal,
    output logic [15:0]        push_data,
    output logic               ack,
    output logic               stall,
    output logic               pc_load,
    output logic [31:0]        pc_out,
    output logic               flags_load,
    output logic [FLAGS_W-1:0] flags_out
);
    state_e             state;
    op_e                op;
    op_e                req_op;
    logic               any_req;
    logic [31:0]        pc_lat;
    logic [31:0]        target_lat;
    logic [FLAGS_W-1:0] flags_lat;
    logic               cap_flags;
    logic               cap_lo;
    logic               cap_hi;
    logic [31:0]        asm_pc;
    logic [FLAGS_W-1:0] asm_flags;

    always_comb begin
        req_op = OP_CALL;
        if (int_req)      req_op = OP_INT;
        else if (rti_req) req_op = OP_RTI;
        else if (ret_req) req_op = OP_RET;
    end

    assign any_req = int_req | rti_req | call_req | ret_req;
    assign ack     = (state == IDLE) && any_req && !rst;
    assign stall   = (state != IDLE) || ack;

    assign cap_flags = (state == POP_LO) && (op == OP_RTI);
    assign cap_lo    = (state == POP_HI);
    assign cap_hi    = (state == CAPTURE);

    stack_word_assembler u_assembler (
        .clk        (clk),
        .rst        (rst),
        .pop_data   (pop_data),
        .cap_flags  (cap_flags),
        .cap_lo     (cap_lo),
        .cap_hi     (cap_hi),
        .pc_word    (asm_pc),
        .flags_word (asm_flags)
    );

    // Stack and load outputs are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= OP_INT;
            pc_lat      <= '0;
            target_lat  <= '0;
            flags_lat   <= '0;
            push_signal <= 1'b0;
            pop_signal  <= 1'b0;
            push_data   <= '0;
            pc_load     <= 1'b0;
            flags_load  <= 1'b0;
            pc_out      <= '0;
            flags_out   <= '0;
        end else begin
            push_signal <= 1'b0;
            pop_signal  <= 1'b0;
            pc_load     <= 1'b0;
            flags_load  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op         <= req_op;
                        pc_lat     <= pc;
                        target_lat <= target;
                        flags_lat  <= flags;
                        if (req_op == OP_INT || req_op == OP_CALL) begin
                            state       <= PUSH_HI;
                            push_signal <= 1'b1;
                            push_data   <= stack_word(WORD_PC_HI, pc, flags);
                        end else if (req_op == OP_RTI) begin
                            state      <= POP_FL;
                            pop_signal <= 1'b1;
                        end else begin
                            state      <= POP_LO;
                            pop_signal <= 1'b1;
                        end
                    end
                end
                PUSH_HI: begin
                    state       <= PUSH_LO;
                    push_signal <= 1'b1;
                    push_data   <= stack_word(WORD_PC_LO, pc_lat, flags_lat);
                end
                PUSH_LO: begin
                    if (op == OP_INT) begin
                        state       <= PUSH_FL;
                        push_signal <= 1'b1;
                        push_data   <= stack_word(WORD_FLAGS, pc_lat, flags_lat);
                    end else begin
                        state   <= LOAD;
                        pc_load <= 1'b1;
                        pc_out  <= target_lat;
                    end
                end
                PUSH_FL: begin
                    state   <= LOAD;
                    pc_load <= 1'b1;
                    pc_out  <= INT_VECTOR;
                end
                POP_FL: begin
                    state      <= POP_LO;
                    pop_signal <= 1'b1;
                end
                POP_LO: begin
                    state      <= POP_HI;
                    pop_signal <= 1'b1;
                end
                POP_HI: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    state   <= LOAD;
                    pc_load <= 1'b1;
                    pc_out  <= asm_pc;
                    if (op == OP_RTI) begin
                        flags_load <= 1'b1;
                        flags_out  <= asm_flags;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: a queue-based data memory plus a transaction
// model predicting pushes, pops, latency and the loaded PC/flags.
module tb_stack_op_sequencer;

    localparam logic [31:0] INT_VEC = 32'h0000_0100;
    localparam int K_INT  = 0;
    localparam int K_RTI  = 1;
    localparam int K_RET  = 2;
    localparam int K_CALL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int_req = 1'b0;
    logic        rti_req = 1'b0;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] target = '0;
    logic [2:0]  flags = '0;
    logic [15:0] pop_data = 16'h0;
    logic        push_signal;
    logic        pop_signal;
    logic [15:0] push_data;
    logic        ack;
    logic        stall;
    logic        pc_load;
    logic [31:0] pc_out;
    logic        flags_load;
    logic [2:0]  flags_out;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [15:0] mem[$];
    logic [15:0] model_stack[$];
    logic [31:0] last_pc = '0;
    logic [2:0]  last_flags = '0;

    stack_op_sequencer #(.INT_VECTOR(INT_VEC)) dut (
        .clk        (clk),
        .rst        (rst),
        .int_req    (int_req),
        .rti_req    (rti_req),
        .call_req   (call_req),
        .ret_req    (ret_req),
        .pc         (pc),
        .target     (target),
        .flags      (flags),
        .pop_data   (pop_data),
        .push_signal(push_signal),
        .pop_signal (pop_signal),
        .push_data  (push_data),
        .ack        (ack),
        .stall      (stall),
        .pc_load    (pc_load),
        .pc_out     (pc_out),
        .flags_load (flags_load),
        .flags_out  (flags_out)
    );

    always #5 clk = ~clk;

    // Data memory: owns the stack, read data appears one cycle after the pop.
    always @(posedge clk) begin
        if (pop_signal) begin
            if (mem.size() > 0) pop_data <= mem.pop_back();
            else                pop_data <= 16'h0;
        end
        if (push_signal) mem.push_back(push_data);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en) checkOutput("push_pop_exclusive", 32'(push_signal && pop_signal), 32'd0);
    end

    task automatic driveReqs(input logic [3:0] r);
        int_req  = r[0];
        rti_req  = r[1];
        ret_req  = r[2];
        call_req = r[3];
    endtask

    task automatic checkIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            checkOutput("idle_ack", 32'(ack), 32'd0);
            checkOutput("idle_stall", 32'(stall), 32'd0);
            checkOutput("idle_push", 32'(push_signal), 32'd0);
            checkOutput("idle_pop", 32'(pop_signal), 32'd0);
            checkOutput("idle_pc_load", 32'(pc_load), 32'd0);
            checkOutput("idle_flags_load", 32'(flags_load), 32'd0);
            checkOutput("idle_pc_out_hold", pc_out, last_pc);
            checkOutput("idle_flags_out_hold", 32'(flags_out), 32'(last_flags));
        end
    endtask

    // One transaction: op must be the winner among op and the extra held requests.
    task automatic applyStimulus(input int op, input logic [31:0] p, input logic [31:0] t,
                                 input logic [2:0] f, input logic [3:0] extra);
        logic [15:0] pushes[$];
        logic [15:0] w_hi, w_lo, w_fl;
        logic [31:0] exp_pc;
        logic [2:0]  exp_flags;
        logic [3:0]  req;
        int lat;
        int npop;
        pushes = {};
        npop = 0;
        lat = 0;
        exp_pc = last_pc;
        exp_flags = last_flags;
        case (op)
            K_INT: begin
                pushes.push_back(p[31:16]);
                pushes.push_back(p[15:0]);
                pushes.push_back({13'b0, f});
                exp_pc = INT_VEC;
                lat = 5;
            end
            K_CALL: begin
                pushes.push_back(p[31:16]);
                pushes.push_back(p[15:0]);
                exp_pc = t;
                lat = 4;
            end
            K_RTI: begin
                w_fl = model_stack.pop_back();
                w_lo = model_stack.pop_back();
                w_hi = model_stack.pop_back();
                exp_pc = {w_hi, w_lo};
                exp_flags = w_fl[2:0];
                npop = 3;
                lat = 6;
            end
            default: begin
                w_lo = model_stack.pop_back();
                w_hi = model_stack.pop_back();
                exp_pc = {w_hi, w_lo};
                npop = 2;
                lat = 5;
            end
        endcase
        foreach (pushes[i]) model_stack.push_back(pushes[i]);
        req = (4'b0001 << op) | extra;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            if (c == 0) begin
                driveReqs(req);
                pc = p;
                target = t;
                flags = f;
            end else begin
                driveReqs(extra);
            end
            #1;
            checkOutput("ack", 32'(ack), 32'(c == 0));
            checkOutput("stall", 32'(stall), 32'd1);
            checkOutput("push_signal", 32'(push_signal), 32'(c >= 1 && c <= pushes.size()));
            if (c >= 1 && c <= pushes.size())
                checkOutput("push_data", 32'(push_data), 32'(pushes[c-1]));
            checkOutput("pop_signal", 32'(pop_signal), 32'(c >= 1 && c <= npop));
            checkOutput("pc_load", 32'(pc_load), 32'(c == lat - 1));
            checkOutput("flags_load", 32'(flags_load), 32'(c == lat - 1 && op == K_RTI));
            if (c == lat - 1) begin
                checkOutput("pc_out", pc_out, exp_pc);
                checkOutput("flags_out", 32'(flags_out), 32'(exp_flags));
            end else if (c == 0) begin
                checkOutput("pc_out_hold", pc_out, last_pc);
                checkOutput("flags_out_hold", 32'(flags_out), 32'(last_flags));
            end
        end
        last_pc = exp_pc;
        last_flags = exp_flags;
    endtask

    initial begin
        int depth;
        int k;
        int kinds[$];

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ack", 32'(ack), 32'd0);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_push", 32'(push_signal), 32'd0);
        checkOutput("reset_pop", 32'(pop_signal), 32'd0);
        checkOutput("reset_push_data", 32'(push_data), 32'd0);
        checkOutput("reset_pc_out", pc_out, 32'd0);
        checkOutput("reset_flags_out", 32'(flags_out), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        checkIdle(2);

        $display("[TB] interrupt entry and RTI round trip");
        applyStimulus(K_INT, 32'h0001_2345, 32'h0, 3'b101, 4'b0000);
        checkIdle(2);
        applyStimulus(K_RTI, 32'h0, 32'h0, 3'b000, 4'b0000);
        checkIdle(1);

        $display("[TB] call and return");
        applyStimulus(K_CALL, 32'h0000_0011, 32'h0000_0040, 3'b000, 4'b0000);
        checkIdle(1);
        applyStimulus(K_RET, 32'h0, 32'h0, 3'b000, 4'b0000);
        checkIdle(1);

        $display("[TB] request priority with held losers");
        applyStimulus(K_INT, 32'hA5A5_0F0F, 32'h0, 3'b011, 4'b1000);
        applyStimulus(K_CALL, 32'h1234_5678, 32'h8765_4320, 3'b000, 4'b0000);
        applyStimulus(K_RET, 32'h0, 32'h0, 3'b000, 4'b1000);
        applyStimulus(K_RTI, 32'h0, 32'h0, 3'b000, 4'b1000);
        applyStimulus(K_CALL, 32'h0BAD_F00D, 32'h0000_2000, 3'b000, 4'b0000);
        applyStimulus(K_RET, 32'h0, 32'h0, 3'b000, 4'b0000);
        checkIdle(1);

        $display("[TB] randomized nested frames");
        for (int it = 0; it < 6; it++) begin
            depth = $urandom_range(1, 3);
            kinds = {};
            for (int d = 0; d < depth; d++) begin
                k = ($urandom_range(0, 1) == 0) ? K_INT : K_CALL;
                kinds.push_back(k);
                applyStimulus(k, $urandom, $urandom, 3'($urandom_range(0, 7)), 4'b0000);
                if ($urandom_range(0, 1) == 1) checkIdle($urandom_range(1, 3));
            end
            while (kinds.size() > 0) begin
                k = kinds.pop_back();
                applyStimulus((k == K_INT) ? K_RTI : K_RET, $urandom, $urandom,
                              3'($urandom_range(0, 7)), 4'b0000);
                if ($urandom_range(0, 1) == 1) checkIdle($urandom_range(1, 2));
            end
        end
        checkIdle(1);

        $display("[TB] reset during push of the low PC word");
        @(negedge clk);
        driveReqs(4'b0001);
        pc = 32'hCAFE_1234;
        flags = 3'b011;
        #1;
        checkOutput("abort_ack", 32'(ack), 32'd1);
        @(negedge clk);
        driveReqs(4'b0000);
        #1;
        checkOutput("abort_push_hi", 32'(push_data), 32'h0000_CAFE);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_push_lo", 32'(push_data), 32'h0000_1234);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_push", 32'(push_signal), 32'd0);
        checkOutput("abort_pop", 32'(pop_signal), 32'd0);
        checkOutput("abort_push_data", 32'(push_data), 32'd0);
        checkOutput("abort_ack_zero", 32'(ack), 32'd0);
        checkOutput("abort_stall", 32'(stall), 32'd0);
        checkOutput("abort_pc_load", 32'(pc_load), 32'd0);
        checkOutput("abort_flags_load", 32'(flags_load), 32'd0);
        checkOutput("abort_pc_out", pc_out, 32'd0);
        checkOutput("abort_flags_out", 32'(flags_out), 32'd0);
        mem.delete();
        model_stack.delete();
        last_pc = '0;
        last_flags = '0;
        checkIdle(4);
        applyStimulus(K_CALL, 32'h0000_7777, 32'h0000_0400, 3'b000, 4'b0000);
        applyStimulus(K_RET, 32'h0, 32'h0, 3'b000, 4'b0000);
        checkIdle(2);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
